// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/decode/issue sequencer with watchdog and retire counter; SEQ_JUMP_EN enables JMP
module instr_sequencer #(
    parameter logic [7:0] START_ADDR = 8'h00,
    parameter int         TIMEOUT    = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        rom_read,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        exec_start,
    output logic [3:0]  opcode,
    output logic [5:0]  dest,
    output logic [5:0]  src,
    input  logic        exec_done,
    output logic [7:0]  pc,
    output logic        busy,
    output logic        halted,
    output logic        err,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_ROM,
        S_DECODE,
        S_EXEC,
        S_WAIT_DONE,
        S_HALT,
        S_ERR
    } state_t;

    localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

    state_t      r_state;
    state_t      w_next_state;
    logic [7:0]  r_pc;
    logic [15:0] r_ir;
    logic [15:0] r_retired;
    logic [7:0]  r_wdog;

    logic        w_restart;
    logic        w_retire;
    logic        w_jump;
    logic        w_wdog_expire;
    logic [3:0]  w_op;

    assign w_op          = r_ir[15:12];
    assign w_wdog_expire = (r_wdog + 8'd1) == TIMEOUT_L;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_restart    = 1'b0;
        w_retire     = 1'b0;
        w_jump       = 1'b0;
        case (r_state)
            S_IDLE, S_HALT, S_ERR: begin
                if (start) begin
                    w_restart    = 1'b1;
                    w_next_state = S_FETCH;
                end
            end
            S_FETCH:    w_next_state = S_WAIT_ROM;
            S_WAIT_ROM: w_next_state = S_DECODE;
            S_DECODE: begin
                if (w_op == 4'h0 || w_op == 4'hF) begin
                    w_next_state = S_HALT;
`ifdef SEQ_JUMP_EN
                end else if (w_op == 4'hD) begin
                    w_jump       = 1'b1;
                    w_next_state = S_FETCH;
`endif
                end else begin
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC:     w_next_state = S_WAIT_DONE;
            S_WAIT_DONE: begin
                // A completion arriving on the final watchdog cycle still retires.
                if (exec_done) begin
                    w_retire     = 1'b1;
                    w_next_state = S_FETCH;
                end else if (w_wdog_expire) begin
                    w_next_state = S_ERR;
                end
            end
            default:    w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= START_ADDR;
            r_ir      <= 16'h0000;
            r_retired <= 16'h0000;
            r_wdog    <= 8'h00;
        end else begin
            if (r_state == S_WAIT_ROM) begin
                r_ir <= rom_data;
            end

            if (w_restart) begin
                r_pc      <= START_ADDR;
                r_retired <= 16'h0000;
            end else if (w_jump || w_retire) begin
                r_pc <= w_jump ? r_ir[7:0] : r_pc + 8'd1;
                if (r_retired != 16'hFFFF) begin
                    r_retired <= r_retired + 16'd1;
                end
            end

            if (r_state == S_EXEC) begin
                r_wdog <= 8'h00;
            end else if (r_state == S_WAIT_DONE && !exec_done) begin
                r_wdog <= r_wdog + 8'd1;
            end
        end
    end

    assign rom_read   = (r_state == S_FETCH);
    assign rom_addr   = r_pc;
    assign exec_start = (r_state == S_EXEC);
    assign opcode     = r_ir[15:12];
    assign dest       = r_ir[11:6];
    assign src        = r_ir[5:0];
    assign pc         = r_pc;
    assign busy       = (r_state == S_FETCH) || (r_state == S_WAIT_ROM) || (r_state == S_DECODE)
                     || (r_state == S_EXEC) || (r_state == S_WAIT_DONE);
    assign halted     = (r_state == S_HALT);
    assign err        = (r_state == S_ERR);
    assign retired    = r_retired;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        rom_read;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        exec_start;
    logic [3:0]  opcode;
    logic [5:0]  dest;
    logic [5:0]  src;
    logic        exec_done;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;
    logic        err;
    logic [15:0] retired;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    instr_sequencer #(.START_ADDR(8'h00), .TIMEOUT(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rom_read(rom_read), .rom_addr(rom_addr), .rom_data(rom_data),
        .exec_start(exec_start), .opcode(opcode), .dest(dest), .src(src),
        .exec_done(exec_done), .pc(pc), .busy(busy), .halted(halted),
        .err(err), .retired(retired)
    );

    // ROM: word appears the cycle after rom_read, junk otherwise.
    logic [15:0] rom [0:255];
    always @(posedge clk) rom_data <= rom_read ? rom[rom_addr] : 16'h5A5A;

    // Executor model: raises done 'delay' cycles after exec_start.
    bit   auto_en = 1'b1;
    int   delay = 1;
    int   cnt = 0;
    logic auto_done = 1'b0;
    logic man_done = 1'b0;
    assign exec_done = (auto_en & auto_done) | man_done;

    always @(negedge clk) begin
        auto_done = 1'b0;
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) auto_done = 1'b1;
        end
        if (exec_start && delay > 0) cnt = delay;
    end

    int         cyc = 0;
    int         n_starts = 0;
    logic [3:0] s_op;
    logic [5:0] s_dest;
    logic [5:0] s_src;
    int         start_cyc[$];
    logic [7:0] fetch_q[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (exec_start) begin
            n_starts++;
            s_op   = opcode;
            s_dest = dest;
            s_src  = src;
            start_cyc.push_back(cyc);
        end
        if (rom_read) fetch_q.push_back(rom_addr);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        n_starts = 0;
        start_cyc.delete();
        fetch_q.delete();
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    endtask

    task automatic start_pulse();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget, input string name);
        int k = 0;
        while (!(halted || err) && k < budget) begin
            tick();
            k++;
        end
        total++;
        if (!(halted || err)) begin
            bad++;
            $display("FAIL %s_wait: no halt/err within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        tick();
        total++;
        if ({rom_read, exec_start, busy, halted, err} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 00000", {rom_read, exec_start, busy, halted, err});
        end
        total++;
        if (pc !== 8'h00 || rom_addr !== 8'h00) begin
            bad++;
            $display("FAIL reset_pc: pc=%h rom_addr=%h want 00", pc, rom_addr);
        end
        total++;
        if ({opcode, dest, src} !== 16'h0000) begin
            bad++;
            $display("FAIL reset_fields: got %h want 0000", {opcode, dest, src});
        end
        total++;
        if (retired !== 16'h0000) begin
            bad++;
            $display("FAIL reset_retired: got %h want 0000", retired);
        end
        rst_n = 1'b1;
        tick();
        tick();
        total++;
        if (busy !== 1'b0 || n_starts != 0) begin
            bad++;
            $display("FAIL idle_after_reset: busy=%b starts=%0d want 0/0", busy, n_starts);
        end
    endtask

    task automatic test_single();
        clear_rom();
        rom[0] = 16'h1042;
        delay = 3;
        clear_mon();
        start_pulse();
        wait_end(60, "single");
        total++;
        if (n_starts != 1) begin
            bad++;
            $display("FAIL single_starts: got %0d want 1", n_starts);
        end
        total++;
        if (s_op !== 4'd1 || s_dest !== 6'd1 || s_src !== 6'd2) begin
            bad++;
            $display("FAIL single_fields: got %h/%h/%h want 1/01/02", s_op, s_dest, s_src);
        end
        total++;
        if (pc !== 8'd1 || retired !== 16'd1 || halted !== 1'b1) begin
            bad++;
            $display("FAIL single_end: pc=%h retired=%h halted=%b want 01/0001/1", pc, retired, halted);
        end
        total++;
        if (fetch_q.size() != 2 || fetch_q[1] !== 8'd1) begin
            bad++;
            $display("FAIL single_fetch: n=%0d want 2 fetches ending at 01", fetch_q.size());
        end
    endtask

    task automatic test_program();
        int k = 0;
        clear_rom();
        rom[0] = 16'h2105;
        rom[1] = 16'h3146;
        delay = 1;
        clear_mon();
        start_pulse();
        while (n_starts == 0 && k < 10) begin
            tick();
            k++;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_end(60, "program");
        total++;
        if (n_starts != 2) begin
            bad++;
            $display("FAIL program_starts: got %0d want 2", n_starts);
        end
        total++;
        if (start_cyc.size() != 2 || start_cyc[1] - start_cyc[0] != 5) begin
            bad++;
            $display("FAIL program_cpi: n=%0d want 2 starts 5 cycles apart", start_cyc.size());
        end
        total++;
        if (s_op !== 4'd3 || s_dest !== 6'd5 || s_src !== 6'd6) begin
            bad++;
            $display("FAIL program_fields: got %h/%h/%h want 3/05/06", s_op, s_dest, s_src);
        end
        total++;
        if (halted !== 1'b1 || pc !== 8'd2 || retired !== 16'd2 || busy !== 1'b0) begin
            bad++;
            $display("FAIL program_end: halted=%b pc=%h retired=%h busy=%b want 1/02/0002/0",
                     halted, pc, retired, busy);
        end
    endtask

    task automatic test_timeout();
        int k = 0;
        clear_rom();
        rom[0] = 16'h4001;
        auto_en = 1'b0;
        clear_mon();
        start_pulse();
        while (exec_start !== 1'b1 && k < 10) begin
            tick();
            k++;
        end
        k = 0;
        while (err !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        // 32 WAIT_DONE samples, err visible on the sample after the 32nd edge
        total++;
        if (k != 33) begin
            bad++;
            $display("FAIL timeout_latency: err after %0d samples want 33", k);
        end
        total++;
        if (pc !== 8'd0 || retired !== 16'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL timeout_state: pc=%h retired=%h busy=%b want 00/0000/0", pc, retired, busy);
        end
        rom[0] = 16'h0000;
        auto_en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (err !== 1'b0 || rom_read !== 1'b1 || rom_addr !== 8'h00) begin
            bad++;
            $display("FAIL timeout_restart: err=%b rom_read=%b addr=%h want 0/1/00", err, rom_read, rom_addr);
        end
        wait_end(20, "timeout");
    endtask

    task automatic test_stray_done();
        clear_rom();
        rom[0] = 16'h5003;
        auto_en = 1'b0;
        clear_mon();
        start_pulse();
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        tick();
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        total++;
        if (exec_start !== 1'b1 || retired !== 16'd0) begin
            bad++;
            $display("FAIL stray_ignored: exec_start=%b retired=%h want 1/0000", exec_start, retired);
        end
        for (int i = 1; i < 32; i++) tick();
        tick();
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        total++;
        if (err !== 1'b0 || retired !== 16'd1 || pc !== 8'd1 || rom_read !== 1'b1) begin
            bad++;
            $display("FAIL done_wins: err=%b retired=%h pc=%h rom_read=%b want 0/0001/01/1",
                     err, retired, pc, rom_read);
        end
        auto_en = 1'b1;
        wait_end(20, "stray");
    endtask

    task automatic test_jump();
`ifdef SEQ_JUMP_EN
        int k = 0;
        logic [7:0] exp_q [5];
        exp_q = '{8'h00, 8'h05, 8'hFE, 8'hFF, 8'h00};
        clear_rom();
        rom[0]     = 16'hD005;
        rom[5]     = 16'hD0FE;
        rom[8'hFE] = 16'h8001;
        rom[8'hFF] = 16'h9002;
        delay = 1;
        clear_mon();
        start_pulse();
        while (!(rom_read === 1'b1 && rom_addr === 8'hFE) && k < 40) begin
            tick();
            k++;
        end
        total++;
        if (n_starts != 0 || retired !== 16'd2) begin
            bad++;
            $display("FAIL jmp_target: starts=%0d retired=%h addr=%h want 0/0002/FE", n_starts, retired, rom_addr);
        end
        rom[0] = 16'h0000;
        wait_end(60, "jump");
        total++;
        if (n_starts != 2 || retired !== 16'd4 || pc !== 8'h00) begin
            bad++;
            $display("FAIL jmp_wrap: starts=%0d retired=%h pc=%h want 2/0004/00", n_starts, retired, pc);
        end
        total++;
        if (fetch_q.size() != 5) begin
            bad++;
            $display("FAIL jmp_fetch_count: got %0d want 5", fetch_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (fetch_q[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL jmp_fetch_%0d: got %h want %h", i, fetch_q[i], exp_q[i]);
                end
            end
        end
`else
        clear_rom();
        rom[0] = 16'hD0FE;
        delay = 1;
        clear_mon();
        start_pulse();
        wait_end(40, "opd");
        total++;
        if (n_starts != 1 || s_op !== 4'hD || s_dest !== 6'd3 || s_src !== 6'h3E) begin
            bad++;
            $display("FAIL opd_issued: starts=%0d fields=%h/%h/%h want 1/D/03/3E", n_starts, s_op, s_dest, s_src);
        end
        total++;
        if (retired !== 16'd1 || pc !== 8'd1 || fetch_q.size() != 2) begin
            bad++;
            $display("FAIL opd_end: retired=%h pc=%h fetches=%0d want 0001/01/2", retired, pc, fetch_q.size());
        end
`endif
    endtask

    task automatic test_reset_mid();
        int k = 0;
        int ns;
        clear_rom();
        rom[0] = 16'h1042;
        rom[1] = 16'hA001;
        delay = 1;
        auto_en = 1'b1;
        clear_mon();
        start_pulse();
        while (!(exec_start === 1'b1 && pc === 8'd1) && k < 30) begin
            tick();
            k++;
        end
        auto_en = 1'b0;
        tick();
        total++;
        if (busy !== 1'b1 || retired !== 16'd1 || opcode !== 4'hA) begin
            bad++;
            $display("FAIL pre_reset: busy=%b retired=%h op=%h want 1/0001/A", busy, retired, opcode);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({rom_read, exec_start, busy, halted, err} !== 5'b0 || pc !== 8'h00) begin
            bad++;
            $display("FAIL async_reset_flags: flags=%b pc=%h want 00000/00",
                     {rom_read, exec_start, busy, halted, err}, pc);
        end
        total++;
        if (retired !== 16'h0000 || {opcode, dest, src} !== 16'h0000) begin
            bad++;
            $display("FAIL async_reset_data: retired=%h fields=%h want 0000/0000", retired, {opcode, dest, src});
        end
        tick();
        rst_n = 1'b1;
        auto_en = 1'b1;
        ns = n_starts;
        repeat (10) tick();
        total++;
        if (n_starts != ns || busy !== 1'b0) begin
            bad++;
            $display("FAIL no_issue_after_reset: starts=%0d busy=%b want %0d/0", n_starts, busy, ns);
        end
        start_pulse();
        total++;
        if (rom_read !== 1'b1 || rom_addr !== 8'h00) begin
            bad++;
            $display("FAIL restart_fetch: rom_read=%b addr=%h want 1/00", rom_read, rom_addr);
        end
        wait_end(60, "reset_mid");
    endtask

    initial begin
        clear_rom();
        test_reset();
        test_single();
        test_program();
        test_timeout();
        test_stray_done();
        test_jump();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Fetch/decode/issue controller placed in front of the control-unit executor. Walks a program counter through the instruction ROM and splits each 16-bit word into opcode/dest/src fields. Issues one instruction at a time to the executor and waits for its completion handshake before advancing. Also handles halt and optional jump, guards against a hung executor with a watchdog, and counts retired instructions.

Parameters:
START_ADDR, 8'h00, PC value loaded on reset and on every start.
TIMEOUT, 32, max cycles spent in WAIT_DONE before ERR (legal range 1..255).

Ports:
clk  input  1  clock, all state updates on posedge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin/restart execution at START_ADDR; honoured only in IDLE, HALT and ERR
rom_read  output  1  ROM read enable, high only in FETCH
rom_addr  output  8  ROM address, equals pc
rom_data  input  16  ROM word, valid the cycle after rom_read
exec_start  output  1  one-cycle pulse, instruction fields valid
opcode  output  4  ir[15:12], held stable from EXEC until done accepted
dest  output  6  ir[11:6]
src  output  6  ir[5:0]
exec_done  input  1  executor completion, sampled only in WAIT_DONE
pc  output  8  current program counter
busy  output  1  high in FETCH, WAIT_ROM, DECODE, EXEC, WAIT_DONE
halted  output  1  high in HALT
err  output  1  high in ERR (watchdog expired)
retired  output  16  retired instruction count, saturating at 16'hFFFF

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=START_ADDR, ir=0, retired=0, watchdog=0. All 1-bit outputs are 0. opcode/dest/src are 0.
- Reset mid-operation aborts immediately. No exec_start is emitted after release until a new start.
- States and transitions:
  - IDLE: start=1 -> FETCH.
  - FETCH: rom_read=1, rom_addr=pc -> WAIT_ROM.
  - WAIT_ROM: ir <= rom_data at the closing edge -> DECODE.
  - DECODE:
    - opcode 4'b0000 or 4'b1111 -> HALT. No exec_start; retired unchanged.
    - opcode 4'b1101 -> see Optional Feature.
    - otherwise -> EXEC.
  - EXEC: exec_start=1 for exactly this cycle; watchdog cleared -> WAIT_DONE.
  - WAIT_DONE: exec_done=1 -> pc <= pc+1, retired <= retired+1 (saturating), -> FETCH. Otherwise watchdog increments; on reaching TIMEOUT -> ERR.
  - HALT: start=1 -> pc=START_ADDR, retired=0 -> FETCH.
  - ERR: start=1 -> pc=START_ADDR, retired=0, err cleared -> FETCH.
- exec_done asserted in any state other than WAIT_DONE is ignored.
- exec_done=1 in the same cycle the watchdog reaches TIMEOUT: done wins and the instruction retires.
- start asserted while busy is ignored.
- PC is 8-bit and wraps 8'hFF -> 8'h00 silently.
- Minimum cycles per instruction: FETCH + WAIT_ROM + DECODE + EXEC + 1 WAIT_DONE = 5 when exec_done arrives on the first WAIT_DONE cycle.
- opcode/dest/src are driven from ir at all times, so they change only at the WAIT_ROM edge.
- All outputs are registered or decoded from state/pc/ir only; no combinational path from inputs to outputs.

Optional Feature:
Macro SEQ_JUMP_EN.
- Defined: opcode 4'b1101 in DECODE is JMP. pc <= ir[7:0] -> FETCH. No exec_start is issued and retired is incremented.
- Not defined: 4'b1101 is passed to the executor like any other opcode (EXEC path).

Test Plan:
- Reset then start; ROM[0]=16'h1042, executor returns done 3 cycles after exec_start -> exec_start pulses once with opcode=1, dest=6'd1, src=6'd2. Then pc=1, retired=1, and FETCH of address 1 follows.
- ROM[0..2]=MVI, ADD, 16'h0000; done one cycle after each start -> exactly 2 exec_start pulses, halted=1, pc=2, retired=2, busy=0.
- Executor never answers with TIMEOUT=32 -> err=1 exactly 32 cycles after entering WAIT_DONE, pc unchanged. A following start clears err and refetches START_ADDR.
- exec_done pulsed during FETCH/DECODE plus on the 32nd WAIT_DONE cycle -> stray pulses ignored, the instruction retires, err stays 0.
- SEQ_JUMP_EN defined, ROM[5]=16'hD0FE, pc=5 -> no exec_start, next rom_addr=8'hFE, retired+1. Running through 8'hFF wraps to 8'h00. Without the macro, opcode D is issued to the executor.
- Drop rst_n for one cycle while in WAIT_DONE -> all outputs return to reset values immediately. No exec_start occurs until start is reasserted.
